// File: rtl/chinx_id_pkg.sv
// Shared types and decode constants for the chinx instruction-decode stage.
// The optional skid buffer in the stage is enabled with CHINX_ID_SKID_EN.
package chinx_id_pkg;

    localparam int ID_PC_W = 32;

    typedef enum logic [1:0] {
        ELOS = 2'd0,
        ELOU = 2'd1,
        EHIZ = 2'd2,
        SHFT = 2'd3
    } ext_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_LSA   = 6'h05;

    typedef struct packed {
        logic [ID_PC_W-1:0] pc;
        ext_sel_e           sel;
        logic [15:0]        imm;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic               use_imm;
        logic               illegal;
    } id_payload_t;

endpackage

// File: rtl/chinx_id_if.sv
// IF -> ID -> EX handshake bundle; the stage uses the slave modport,
// the surrounding pipeline (IF producer / EX consumer) uses master.
interface chinx_id_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [1:0]      out_sel;
    logic [15:0]     out_imm;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic            out_use_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_sel, out_imm,
        output out_rs, out_rt, out_rd, out_use_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_sel, out_imm,
        input  out_rs, out_rt, out_rd, out_use_imm, out_illegal
    );
endinterface

// File: rtl/chinx_id_decode.sv
// Combinational instruction decoder: extender select, immediate, register
// indices and control flags from one 32-bit instruction word.
module chinx_id_decode
    import chinx_id_pkg::*;
(
    input  logic [31:0] i_instr,
    output ext_sel_e    o_sel,
    output logic [15:0] o_imm,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic        o_use_imm,
    output logic        o_illegal
);
    logic [5:0] w_op;
    logic [5:0] w_funct;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];
    assign o_rs    = i_instr[25:21];
    assign o_rt    = i_instr[20:16];
    assign o_rd    = i_instr[15:11];

    // Opcode/funct classification into extender mode and operand-B source
    always_comb begin
        o_sel     = ELOS;
        o_imm     = i_instr[15:0];
        o_use_imm = 1'b0;
        o_illegal = 1'b0;
        case (w_op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                o_sel     = ELOS;
                o_use_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_sel     = ELOS;
                o_use_imm = 1'b0;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                o_sel     = ELOU;
                o_use_imm = 1'b1;
            end
            OP_LUI: begin
                o_sel     = EHIZ;
                o_use_imm = 1'b1;
            end
            OP_RTYPE: begin
                // LSA carries its 2-bit shift amount in the extender operand
                if (w_funct == FN_LSA) begin
                    o_sel = SHFT;
                    o_imm = {14'd0, i_instr[7:6]};
                end else begin
                    o_sel = ELOS;
                    o_imm = i_instr[15:0];
                end
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/chinx_id_stage.sv
// ID pipeline stage: decodes IF instructions into a registered ID/EX payload
// with valid/ready flow control and flush. CHINX_ID_SKID_EN adds a skid entry.
module chinx_id_stage
    import chinx_id_pkg::*;
#(
    parameter int PC_W = 32   // must not exceed ID_PC_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    chinx_id_if.slave  io_bus
);
    ext_sel_e    w_sel;
    logic [15:0] w_imm;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_use_imm;
    logic        w_illegal;
    id_payload_t w_dec;
    id_payload_t r_out;
    logic        r_out_valid;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_retire;

    chinx_id_decode u_decode (
        .i_instr   (io_bus.in_instr),
        .o_sel     (w_sel),
        .o_imm     (w_imm),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_rd      (w_rd),
        .o_use_imm (w_use_imm),
        .o_illegal (w_illegal)
    );

    // Assemble the decoded payload for the incoming instruction
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = ID_PC_W'(io_bus.in_pc);
        w_dec.sel     = w_sel;
        w_dec.imm     = w_imm;
        w_dec.rs      = w_rs;
        w_dec.rt      = w_rt;
        w_dec.rd      = w_rd;
        w_dec.use_imm = w_use_imm;
        w_dec.illegal = w_illegal;
    end

    assign w_accept = io_bus.in_valid & w_in_ready;
    // Flush wins over retire so nothing moves in the flush cycle
    assign w_retire = r_out_valid & io_bus.out_ready & ~io_bus.flush;

`ifdef CHINX_ID_SKID_EN
    id_payload_t r_skid;
    logic        r_skid_valid;

    assign w_in_ready = i_rst_n & ~io_bus.flush & ~r_skid_valid;

    // Valid bits of the output register and the skid entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (io_bus.flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_retire) begin
            r_out_valid  <= r_skid_valid | w_accept;
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_skid_valid <= r_out_valid;
        end else begin
            r_out_valid  <= r_out_valid;
            r_skid_valid <= r_skid_valid;
        end
    end

    // Payload movement: skid drains first, so accept and skid never collide
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else if (w_retire && r_skid_valid) begin
            r_out  <= r_skid;
        end else if (w_accept && (w_retire || !r_out_valid)) begin
            r_out  <= w_dec;
        end else if (w_accept) begin
            r_skid <= w_dec;
        end else begin
            r_out  <= r_out;
            r_skid <= r_skid;
        end
    end
`else
    assign w_in_ready = i_rst_n & ~io_bus.flush & (~r_out_valid | io_bus.out_ready);

    // Output valid bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
        end else if (io_bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (w_retire) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Payload register, loaded only on accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else if (w_accept) begin
            r_out <= w_dec;
        end else begin
            r_out <= r_out;
        end
    end
`endif

    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_pc      = r_out.pc[PC_W-1:0];
    assign io_bus.out_sel     = r_out.sel;
    assign io_bus.out_imm     = r_out.imm;
    assign io_bus.out_rs      = r_out.rs;
    assign io_bus.out_rt      = r_out.rt;
    assign io_bus.out_rd      = r_out.rd;
    assign io_bus.out_use_imm = r_out.use_imm;
    assign io_bus.out_illegal = r_out.illegal;

endmodule

// File: tb/tb_chinx_id_stage.sv
// Self-checking bench for chinx_id_stage: queue-based transfer model with a
// rule-level decoder, plus hand-computed checks. Honours CHINX_ID_SKID_EN.
module tb_chinx_id_stage;
    localparam int PC_W = 32;
`ifdef CHINX_ID_SKID_EN
    localparam int DEPTH   = 2;
    localparam int EXP_ABS = 1;
`else
    localparam int DEPTH   = 1;
    localparam int EXP_ABS = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chinx_id_if #(.PC_W(PC_W)) bus ();
    chinx_id_stage #(.PC_W(PC_W)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [4:0]  rs, rt, rd;
        logic        use_imm, illegal;
    } exp_t;

    exp_t mq[$];
    bit   m_acc = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    function automatic exp_t model_decode(logic [31:0] w, logic [31:0] pc);
        exp_t       e;
        logic [5:0] op;
        op        = w[31:26];
        e.pc      = pc;
        e.rs      = w[25:21];
        e.rt      = w[20:16];
        e.rd      = w[15:11];
        e.imm     = w[15:0];
        e.sel     = 2'd0;
        e.use_imm = 1'b0;
        e.illegal = 1'b0;
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05}) begin
            e.use_imm = (op != 6'h04) && (op != 6'h05);
        end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
            e.sel = 2'd1;
            e.use_imm = 1'b1;
        end else if (op == 6'h0F) begin
            e.sel = 2'd2;
            e.use_imm = 1'b1;
        end else if (op == 6'h00 && w[5:0] == 6'h05) begin
            e.sel = 2'd3;
            e.imm = {14'd0, w[7:6]};
        end else if (op != 6'h00) begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic bit m_ready();
        if (!rst_n || bus.flush) return 1'b0;
        if (DEPTH == 1) return (mq.size() == 0) || bus.out_ready;
        return mq.size() < DEPTH;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer model: ordered queue of accepted instructions
    always @(posedge clk or negedge rst_n) begin
        bit r;
        if (!rst_n) begin
            mq.delete();
            m_acc = 1'b0;
        end else begin
            r = m_ready();
            m_acc = 1'b0;
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
                if (bus.in_valid && r) begin
                    mq.push_back(model_decode(bus.in_instr, bus.in_pc));
                    m_acc = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("in_ready", bus.in_ready, m_ready());
        check("out_valid", bus.out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("out_pc", bus.out_pc, mq[0].pc);
            check("out_sel", bus.out_sel, mq[0].sel);
            check("out_imm", bus.out_imm, mq[0].imm);
            check("out_regs", {bus.out_rs, bus.out_rt, bus.out_rd},
                  {mq[0].rs, mq[0].rt, mq[0].rd});
            check("out_flags", {bus.out_use_imm, bus.out_illegal},
                  {mq[0].use_imm, mq[0].illegal});
        end
    end

    task automatic drive(bit v, logic [31:0] instr, logic [31:0] pc, bit ordy, bit fl);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string name);
        check(name, {bus.out_valid, bus.out_pc, bus.out_sel, bus.out_imm},
              {1'b0, 32'h0, 2'b00, 16'h0});
        check({name, "_regs"}, {bus.out_rs, bus.out_rt, bus.out_rd, bus.out_use_imm,
              bus.out_illegal, bus.in_ready}, 18'h0);
    endtask

    logic [31:0] stall_list [4] = '{32'h306200FF, 32'h3843AAAA, 32'h2529_8000, 32'h0085_1020};
    logic [31:0] mix_list  [9] = '{32'h2529_8000, 32'h2D4A_0010, 32'h8FBF_0014, 32'hAFBF_0018,
                                   32'h1085_FFFE, 32'h14A6_0003, 32'h0085_1020, 32'h0800_0010,
                                   32'h0085_10C5};

    initial begin
        int idx;
        int guard;
        int absorbed;
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", bus.in_ready, 1'b1);

        // ADDI with immediate downstream consumption
        drive(1'b1, 32'h2008FFFC, 32'h100, 1'b1, 1'b0);
        check("addi_valid", bus.out_valid, 1'b1);
        check("addi_sel", bus.out_sel, 2'd0);
        check("addi_imm", bus.out_imm, 16'hFFFC);
        check("addi_rs_rt", {bus.out_rs, bus.out_rt}, {5'd0, 5'd8});
        check("addi_use_imm", bus.out_use_imm, 1'b1);
        check("addi_pc", bus.out_pc, 32'h100);

        // Back-to-back ORI, LUI, LSA
        drive(1'b1, 32'h3421ABCD, 32'h104, 1'b1, 1'b0);
        check("ori_sel_imm", {bus.out_sel, bus.out_imm}, {2'd1, 16'hABCD});
        drive(1'b1, 32'h3C011234, 32'h108, 1'b1, 1'b0);
        check("lui_sel_imm", {bus.out_sel, bus.out_imm}, {2'd2, 16'h1234});
        drive(1'b1, 32'h00851045, 32'h10C, 1'b1, 1'b0);
        check("lsa_sel_imm", {bus.out_sel, bus.out_imm}, {2'd3, 16'h0001});
        check("lsa_use_imm", bus.out_use_imm, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drained", bus.out_valid, 1'b0);

        // Backpressure for 3 cycles while IF keeps streaming
        drive(1'b1, stall_list[0], 32'h200, 1'b0, 1'b0);
        idx = 1;
        absorbed = 0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1; bus.in_instr = stall_list[idx];
            bus.in_pc = 32'h200 + 32'(4 * idx); bus.out_ready = 1'b0;
            #1;
            if (bus.in_ready) absorbed++;
            @(posedge clk);
            #1;
            if (m_acc) idx++;
            check("stall_pc_stable", bus.out_pc, 32'h200);
            check("stall_imm_stable", bus.out_imm, 16'h00FF);
        end
        check("stall_absorbed", absorbed, EXP_ABS);
        guard = 0;
        while (idx < 4 && guard < 20) begin
            drive(1'b1, stall_list[idx], 32'h200 + 32'(4 * idx), 1'b1, 1'b0);
            if (m_acc) idx++;
            guard++;
        end
        check("stall_all_accepted", idx, 4);
        repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a valid payload and a presented instruction
        drive(1'b1, 32'h38435555, 32'h300, 1'b0, 1'b0);
        drive(1'b1, 32'h2901_0007, 32'h304, 1'b0, 1'b0);
        bus.in_valid = 1'b1; bus.in_instr = 32'h2109_0001; bus.in_pc = 32'h308;
        bus.out_ready = 1'b1; bus.flush = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("flush_clears", bus.out_valid, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_nothing_left", bus.out_valid, 1'b0);

        // Illegal opcode 0x3F flows through
        drive(1'b1, 32'hFC00_0000, 32'h400, 1'b1, 1'b0);
        check("illegal_flags", {bus.out_valid, bus.out_illegal, bus.out_use_imm}, 3'b110);

        // Mixed opcodes under an irregular OUT_READY pattern
        idx = 0;
        guard = 0;
        while (idx < 9 && guard < 60) begin
            drive(1'b1, mix_list[idx], 32'h440 + 32'(4 * idx), (guard % 3) != 1, 1'b0);
            if (m_acc) idx++;
            guard++;
        end
        check("mix_all_accepted", idx, 9);
        repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset in the middle of a stalled transfer
        drive(1'b1, 32'h3C01_5A5A, 32'h500, 1'b0, 1'b0);
        drive(1'b1, 32'h3421_0F0F, 32'h504, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("midstream_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h2008FFFC, 32'h600, 1'b1, 1'b0);
        check("replay_pc", {bus.out_valid, bus.out_pc}, {1'b1, 32'h600});
        repeat (2) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
